// File: rtl/nes_dma_engine.sv
// nes_dma_engine: bus-owning DMA for the 2A03 core. Copies a sprite page to
// the OAM data port and fetches DMC sample bytes, halting the CPU through
// cpu_rdy. Get/put parity keeps reads on get cycles and writes on put cycles.
// A pending DMC fetch steals the next GET slot from a running sprite copy.
module nes_dma_engine #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] SPR_DEST  = 16'h2004,
    parameter int          SPR_LEN   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_a,
    input  logic        cpu_r_nw,
    input  logic [7:0]  cpu_dout,
    input  logic [7:0]  mem_din,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic [15:0] dma_a,
    output logic [7:0]  dma_dout,
    output logic        dma_r_nw,
    output logic        dma_active,
    output logic        cpu_rdy,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_GET   = 3'd3,
        S_PUT   = 3'd4
    } state_t;

    // Index of the last sprite byte; idx never advances past it.
    localparam logic [7:0] LAST_IDX = 8'(SPR_LEN - 1);

    state_t      state_q, state_d;
    logic        parity_q;
    logic [7:0]  idx_q, idx_d;
    logic        spr_pend_q, spr_pend_d;
    logic        dmc_pend_q, dmc_pend_d;
    logic [7:0]  page_q;
    logic [7:0]  buf_q;
    logic [7:0]  dmc_data_q;
    logic        dmc_ack_q;

    logic        trig;
    logic        dmc_serve;
    logic        spr_read;
    logic        spr_done;

    // Qualified events for the current CPU cycle.
    always_comb begin
        trig      = cpu_ce && !cpu_r_nw && (cpu_a == TRIG_ADDR) && (state_q == S_IDLE);
        dmc_serve = cpu_ce && (state_q == S_GET) && dmc_pend_q;
        spr_read  = cpu_ce && (state_q == S_GET) && !dmc_pend_q;
        spr_done  = cpu_ce && (state_q == S_PUT) && (idx_q == LAST_IDX);
    end

    // Pending-request flags: serve/finish clears win over a simultaneous set.
    always_comb begin
        spr_pend_d = spr_pend_q;
        dmc_pend_d = dmc_pend_q;
        if (trig)
            spr_pend_d = 1'b1;
        if (spr_done)
            spr_pend_d = 1'b0;
        if (cpu_ce && dmc_req)
            dmc_pend_d = 1'b1;
        if (dmc_serve)
            dmc_pend_d = 1'b0;
    end

    // Sprite index: advances after each PUT, returns to 0 after the last byte.
    always_comb begin
        idx_d = idx_q;
        if (cpu_ce && (state_q == S_PUT))
            idx_d = (idx_q == LAST_IDX) ? 8'd0 : idx_q + 8'd1;
    end

    // FSM next state: one state visit per CPU cycle.
    always_comb begin
        state_d = state_q;
        if (cpu_ce) begin
            case (state_q)
                S_IDLE:  if (spr_pend_d || dmc_pend_d) state_d = S_HALT;
                // parity_q=0 means this HALT is a get cycle, so the next one is a put.
                S_HALT:  state_d = parity_q ? S_GET : S_ALIGN;
                S_ALIGN: state_d = S_GET;
                S_GET: begin
                    if (dmc_pend_q)
                        state_d = spr_pend_q ? S_ALIGN : S_IDLE;
                    else
                        state_d = S_PUT;
                end
                S_PUT:   state_d = (idx_q == LAST_IDX) ? S_IDLE : S_GET;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM state register and control flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            parity_q   <= 1'b0;
            idx_q      <= 8'd0;
            spr_pend_q <= 1'b0;
            dmc_pend_q <= 1'b0;
            dmc_ack_q  <= 1'b0;
            dmc_data_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            spr_pend_q <= spr_pend_d;
            dmc_pend_q <= dmc_pend_d;
            dmc_ack_q  <= dmc_serve;
            if (cpu_ce)
                parity_q <= ~parity_q;
            if (dmc_serve)
                dmc_data_q <= mem_din;
        end
    end

    // Data holding registers: page latched on trigger, sprite byte on each GET.
    always_ff @(posedge clk) begin
        if (trig)
            page_q <= cpu_dout;
        if (spr_read)
            buf_q <= mem_din;
    end

    // FSM outputs: bus drive decoded from the current state.
    always_comb begin
        cpu_rdy    = (state_q == S_IDLE);
        dma_active = (state_q == S_GET) || (state_q == S_PUT);
        dma_r_nw   = (state_q != S_PUT);
        dma_a      = 16'd0;
        dma_dout   = 8'd0;
        case (state_q)
            S_GET:   dma_a = dmc_pend_q ? dmc_addr : {page_q, idx_q};
            S_PUT: begin
                dma_a    = SPR_DEST;
                dma_dout = buf_q;
            end
            default: dma_a = 16'd0;
        endcase
    end

    assign dmc_ack  = dmc_ack_q;
    assign dmc_data = dmc_data_q;

endmodule
